// File: rtl/elu_table_loader_pkg.sv
// Shared constants and state encoding for the ELU table writer.
// Build option: ELU_TABLE_CHECKSUM_EN adds a trailing checksum word to every load.
package elu_table_loader_pkg;

  localparam int unsigned EluTableWords  = 1597;
  localparam int unsigned EluTableAwidth = 11;
  localparam int unsigned EluTableDwidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StFin
  } load_state_e;

endpackage

// File: rtl/elu_table_ram.sv
// ELU table storage: one write port fed by the loader, one registered read port for lookup.
module elu_table_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 11,
  parameter int unsigned WORDS  = 1597
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [WORDS];
  logic [DWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AWIDTH'(WORDS))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en && (rd_addr < AWIDTH'(WORDS))) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/elu_table_loader.sv
// Streams WORDS table words over valid/ready into the ELU table RAM at addresses 0..WORDS-1.
// Build option: ELU_TABLE_CHECKSUM_EN (one extra stream word carrying the mod-2^DWIDTH sum).
module elu_table_loader
  import elu_table_loader_pkg::*;
#(
  parameter int unsigned DWIDTH = EluTableDwidth,
  parameter int unsigned AWIDTH = EluTableAwidth,
  parameter int unsigned WORDS  = EluTableWords
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              table_valid,
  output logic              err
);

  localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(WORDS - 1);

  load_state_e       state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DWIDTH-1:0] wr_data_q, wr_data_d;
  logic              table_valid_q, table_valid_d;
  logic              hs;
`ifdef ELU_TABLE_CHECKSUM_EN
  logic              err_q, err_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
`endif

  // Ready depends only on registered state, never on s_valid.
  assign s_ready = (state_q == StLoad) || (state_q == StCheck);
  assign hs      = s_valid & s_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    table_valid_d = table_valid_q;
`ifdef ELU_TABLE_CHECKSUM_EN
    err_d         = err_q;
    sum_d         = sum_q;
`endif
    if (start) begin
      // Restart wins over any handshake in the same cycle; that word is dropped.
      state_d       = StLoad;
      cnt_d         = '0;
      table_valid_d = 1'b0;
`ifdef ELU_TABLE_CHECKSUM_EN
      err_d         = 1'b0;
      sum_d         = '0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (hs) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = s_data;
`ifdef ELU_TABLE_CHECKSUM_EN
            sum_d     = sum_q + s_data;
`endif
            if (cnt_q == LastAddr) begin
`ifdef ELU_TABLE_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d       = StFin;
              table_valid_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StCheck: begin
`ifdef ELU_TABLE_CHECKSUM_EN
          if (hs) begin
            state_d = StFin;
            if (s_data == sum_q) begin
              table_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
`else
          state_d = StIdle;
`endif
        end
        StFin:   state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      table_valid_q <= 1'b0;
`ifdef ELU_TABLE_CHECKSUM_EN
      err_q         <= 1'b0;
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      table_valid_q <= table_valid_d;
`ifdef ELU_TABLE_CHECKSUM_EN
      err_q         <= err_d;
      sum_q         <= sum_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = s_ready;
  assign done        = (state_q == StFin);
  assign table_valid = table_valid_q;
`ifdef ELU_TABLE_CHECKSUM_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

  logic [DWIDTH-1:0] rd_data_unused;

  // Lookup read port is not used by the writer; it stays idle here.
  elu_table_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .WORDS  (WORDS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (1'b0),
    .rd_addr ('0),
    .rd_data (rd_data_unused)
  );

endmodule

// File: tb/tb_elu_table_loader.sv
// Bench for elu_table_loader: directed load sessions with random data and valid patterns.
module tb_elu_table_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 11;
  localparam int unsigned NW = 1597;
`ifdef ELU_TABLE_CHECKSUM_EN
  localparam int XW = 1;
`else
  localparam int XW = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, wr_en, busy, done, table_valid, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  elu_table_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          dc[$];
  logic [7:0]  stream[$];

  always @(posedge clk) cyc = cyc + 1;

  // Write/done monitor, sampled well after the edge.
  always @(posedge clk) begin
    #2;
    if (wr_en !== 1'b0) begin
      wa.push_back(32'(wr_addr));
      wd.push_back(32'(wr_data));
      wc.push_back(cyc);
    end
    if (done === 1'b1) dc.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  // Reference stream: NW table words, plus the modular sum when checksums are built in.
  task automatic fill(input bit ramp);
    int s = 0;
    stream.delete();
    for (int i = 0; i < int'(NW); i++) begin
      stream.push_back(ramp ? 8'(i % 256) : 8'($urandom_range(0, 255)));
      s = (s + int'(stream[i])) % 256;
    end
    if (XW != 0) stream.push_back(8'(s));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: every other cycle, 2: random
  task automatic send(input int n, input int mode);
    int idx = 0;
    int budget = 0;
    int ph = 0;
    while (idx < n && budget < 8 * n + 100) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = ph[0];
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      ph++;
      s_data = stream[idx];
      #1;
      if (s_valid && s_ready === 1'b1) idx++;
      @(negedge clk);
      budget++;
    end
    s_valid = 1'b0;
    chk("send_accepted", 32'(idx), 32'(n));
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_table_valid"}, 32'(table_valid), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
    chk({tag, "_table_valid_after"}, 32'(table_valid), 32'd1);
  endtask

  task automatic check_log(input string tag, input bit contiguous);
    int bad = 0;
    chk({tag, "_write_count"}, 32'(wa.size()), 32'(NW));
    for (int i = 0; i < wa.size() && i < int'(NW); i++) begin
      if (wa[i] !== 32'(i) || wd[i] !== 32'(stream[i])) bad++;
    end
    chk({tag, "_write_content_errors"}, 32'(bad), 32'd0);
    chk({tag, "_done_pulses"}, 32'(dc.size()), 32'd1);
    if (wc.size() == int'(NW) && dc.size() > 0) begin
      if (contiguous) begin
        chk({tag, "_write_span"}, 32'(wc[NW-1] - wc[0]), 32'(NW - 1));
        chk({tag, "_done_cycle"}, 32'(dc[0]), 32'(wc[NW-1] + XW));
      end else begin
        chk({tag, "_done_after_writes"}, 32'(dc[0] >= wc[NW-1]), 32'd1);
      end
    end
  endtask

  initial begin
    // 1: reset held with valid asserted
    s_valid = 1'b1;
    s_data  = 8'h5a;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_table_valid", 32'(table_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_no_writes", 32'(wa.size()), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    chk("idle_no_writes", 32'(wa.size()), 32'd0);
    s_valid = 1'b0;

    // 2: full ramp load, valid held high
    clear_logs();
    fill(1'b1);
    pulse_start();
    chk("ramp_ready_after_start", 32'(s_ready), 32'd1);
    send(int'(NW) + XW, 0);
    post_checks("ramp");
    check_log("ramp", 1'b1);

    // 3: random data, valid every other cycle
    clear_logs();
    fill(1'b0);
    pulse_start();
    send(int'(NW) + XW, 1);
    post_checks("bubble");
    check_log("bubble", 1'b0);

    // 4: restart just after the write to address 700
    clear_logs();
    fill(1'b0);
    pulse_start();
    chk("restart_tv_cleared", 32'(table_valid), 32'd0);
    send(701, 2);
    chk("restart_pre_count", 32'(wa.size()), 32'd701);
    chk("restart_pre_last_addr", (wa.size() > 0) ? wa[wa.size()-1] : 32'hffff_ffff, 32'd700);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'haa;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    chk("restart_tv", 32'(table_valid), 32'd0);
    chk("restart_ready", 32'(s_ready), 32'd1);
    chk("restart_dropped_word", 32'(wa.size()), 32'd701);
    clear_logs();
    fill(1'b0);
    send(int'(NW) + XW, 0);
    post_checks("restart");
    check_log("restart", 1'b1);

    // 5: async reset while address 300 is being written
    clear_logs();
    fill(1'b0);
    pulse_start();
    send(301, 2);
    chk("areset_pre_wr_en", 32'(wr_en), 32'd1);
    chk("areset_pre_wr_addr", 32'(wr_addr), 32'd300);
    s_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_wr_en", 32'(wr_en), 32'd0);
    chk("areset_wr_addr", 32'(wr_addr), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_ready", 32'(s_ready), 32'd0);
    chk("areset_tv", 32'(table_valid), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    clear_logs();
    fill(1'b0);
    pulse_start();
    send(int'(NW) + XW, 2);
    post_checks("reload");
    check_log("reload", 1'b0);

`ifdef ELU_TABLE_CHECKSUM_EN
    // 6: explicit good and bad checksum on the ramp table
    clear_logs();
    fill(1'b1);
    stream[NW] = 8'h26;
    pulse_start();
    send(int'(NW) + 1, 0);
    post_checks("csum_good");
    clear_logs();
    stream[NW] = 8'h27;
    pulse_start();
    send(int'(NW) + 1, 0);
    chk("csum_bad_done", 32'(done), 32'd1);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_tv", 32'(table_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("csum_bad_err_sticky", 32'(err), 32'd1);
    chk("csum_bad_writes", 32'(wa.size()), 32'(NW));
    pulse_start();
    chk("csum_err_cleared", 32'(err), 32'd0);
`else
    chk("nocsum_err_tied", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
